r4mdc_sequencer: RTL

- Control FSM for the 16-point radix-4 MDC FFT datapath: two butterfly stages, each fed by a commutator.
- Accepts a frame start and gates the 16-sample input load.
- Drives commutator enables/selects and the inter-stage twiddle index.
- Tracks butterfly valid pulses, flags protocol errors with a watchdog, and pulses done at frame end.
- Sits beside the datapath in the R4MDC top level, in place of the simple enable-only control.

---
 rtl/r4mdc_pkg.sv | 19 +
 rtl/r4mdc_op_counter.sv | 34 +++
 rtl/r4mdc_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/r4mdc_pkg.sv
// Shared types and constants for the 16-point radix-4 MDC FFT control path.
package r4mdc_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PROC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Frame geometry: 16 samples, four radix-4 operations per stage
  localparam int N_PTS         = 16;
  localparam int OPS_PER_STAGE = 4;

  // Width of a per-stage op counter (holds 0..OPS_PER_STAGE)
  localparam int CNT_W = 3;

endpackage

// File: rtl/r4mdc_op_counter.sv
// Per-stage radix-4 op counter. A request is accepted only while the count is
// below the supplied limit; a request at or above the limit is flagged as an
// overflow and leaves the count untouched, so the count saturates at the limit.
module r4mdc_op_counter
  import r4mdc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_req,
  input  logic [CNT_W-1:0] i_limit,
  output logic [CNT_W-1:0] o_count,
  output logic             o_accept,
  output logic             o_overflow
);

  logic [CNT_W-1:0] r_count;

  assign o_accept   = i_req && (r_count < i_limit);
  assign o_overflow = i_req && !o_accept;
  assign o_count    = r_count;

  // Count accepted ops; clear wins over an increment in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (o_accept) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/r4mdc_sequencer.sv
// Control FSM for the 16-point radix-4 MDC FFT: gates the 16-sample load,
// steers both commutators and the twiddle index, tracks butterfly progress,
// and reports completion or protocol errors. All outputs are registered.
module r4mdc_sequencer
  import r4mdc_pkg::*;
#(
  parameter int LOG2N   = 4,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       but1_valid,
  input  logic       but2_valid,
  output logic       sample_en,
  output logic       comm1_en,
  output logic [1:0] comm1_sel,
  output logic       comm2_en,
  output logic [1:0] comm2_sel,
  output logic [1:0] tw_idx,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [LOG2N-1:0] LC_LAST = LOG2N'(N_PTS - 1);
  localparam logic [CNT_W-1:0] OPS_MAX = CNT_W'(OPS_PER_STAGE);
  localparam logic [TO_W-1:0]  TO_LIM  = TO_W'(TIMEOUT);

  state_t           r_state, w_state_next;
  logic [LOG2N-1:0] r_lc, w_lc_next;
  logic [TO_W-1:0]  r_wd, w_wd_next;

  logic             w_in_proc, w_cnt_clr, w_any_valid, w_timeout;
  logic [TO_W-1:0]  w_wd_inc;
  logic [CNT_W-1:0] w_c1_count, w_c2_count, w_c1_after, w_c2_after;
  logic             w_c1_acc, w_c1_ovf, w_c2_acc, w_c2_ovf;

  logic             w_sample_en_next, w_comm1_en_next, w_comm2_en_next;
  logic [1:0]       w_comm1_sel_next, w_comm2_sel_next, w_tw_idx_next;
  logic             w_busy_next, w_done_next, w_err_next;

  assign w_in_proc   = (r_state == ST_PROC);
  assign w_cnt_clr   = (r_state == ST_LOAD) && (r_lc == LC_LAST);
  assign w_any_valid = but1_valid || but2_valid;
  assign w_wd_inc    = r_wd + TO_W'(1);
  assign w_timeout   = w_in_proc && !w_any_valid && (w_wd_inc == TO_LIM);

  // Stage 1 may run up to four ops; stage 2 may never overtake stage 1
  r4mdc_op_counter u_cnt1 (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_cnt_clr),
    .i_req      (w_in_proc && but1_valid),
    .i_limit    (OPS_MAX),
    .o_count    (w_c1_count),
    .o_accept   (w_c1_acc),
    .o_overflow (w_c1_ovf)
  );

  r4mdc_op_counter u_cnt2 (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_cnt_clr),
    .i_req      (w_in_proc && but2_valid),
    .i_limit    (w_c1_count),
    .o_count    (w_c2_count),
    .o_accept   (w_c2_acc),
    .o_overflow (w_c2_ovf)
  );

  assign w_c1_after = w_c1_count + CNT_W'(w_c1_acc);
  assign w_c2_after = w_c2_count + CNT_W'(w_c2_acc);

  // State, load counter and watchdog registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_lc    <= '0;
      r_wd    <= '0;
    end else begin
      r_state <= w_state_next;
      r_lc    <= w_lc_next;
      r_wd    <= w_wd_next;
    end
  end

  // Next-state logic and next values of the registered outputs
  always_comb begin
    w_state_next     = r_state;
    w_lc_next        = r_lc;
    w_wd_next        = r_wd;
    w_sample_en_next = 1'b0;
    w_comm1_en_next  = 1'b0;
    w_comm1_sel_next = 2'd0;
    w_comm2_en_next  = 1'b0;
    w_comm2_sel_next = 2'd0;
    w_tw_idx_next    = 2'd0;
    w_busy_next      = 1'b0;
    w_done_next      = 1'b0;
    w_err_next       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_err_next = w_any_valid;
        if (start) begin
          w_state_next = ST_LOAD;
          w_lc_next    = '0;
        end
      end
      ST_LOAD: begin
        w_lc_next = r_lc + LOG2N'(1);
        if (r_lc == LC_LAST) begin
          w_state_next = ST_PROC;
          w_wd_next    = '0;
        end
      end
      ST_PROC: begin
        w_wd_next  = w_any_valid ? '0 : w_wd_inc;
        w_err_next = w_c1_ovf || w_c2_ovf || w_timeout;
        // Stage-2 commutator and twiddle follow the op just finished by stage 1
        if (w_c1_acc) begin
          w_comm2_en_next  = 1'b1;
          w_comm2_sel_next = w_c1_count[1:0];
          w_tw_idx_next    = w_c1_count[1:0];
        end
        if (w_timeout) begin
          w_state_next = ST_IDLE;
        end else if ((w_c1_after == OPS_MAX) && (w_c2_after == OPS_MAX)) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Load-phase and status outputs line up with the state they describe
    if (w_state_next == ST_LOAD) begin
      w_sample_en_next = 1'b1;
      w_comm1_en_next  = 1'b1;
      w_comm1_sel_next = w_lc_next[LOG2N-1 -: 2];
    end
    w_busy_next = (w_state_next != ST_IDLE);
    w_done_next = (w_state_next == ST_DONE);
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_en <= 1'b0;
      comm1_en  <= 1'b0;
      comm1_sel <= 2'd0;
      comm2_en  <= 1'b0;
      comm2_sel <= 2'd0;
      tw_idx    <= 2'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      sample_en <= w_sample_en_next;
      comm1_en  <= w_comm1_en_next;
      comm1_sel <= w_comm1_sel_next;
      comm2_en  <= w_comm2_en_next;
      comm2_sel <= w_comm2_sel_next;
      tw_idx    <= w_tw_idx_next;
      busy      <= w_busy_next;
      done      <= w_done_next;
      err       <= w_err_next;
    end
  end

endmodule
